core_fetch_arbiter: RTL

CORE_FETCH_ARBITER -- requirements
Module: core_fetch_arbiter

---
 rtl/core_fetch_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/core_fetch_arbiter.sv
// Shares one memory port between the instruction prefetcher and the load/store unit.
// Data requests win arbitration until fetch has been starved for STARVE_MAX grants.
module core_fetch_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [30:0] head,
    input  logic        fetch,
    output logic        fetched,
    output logic [31:0] fetch_data,
    input  logic        data_start,
    input  logic        data_write,
    input  logic [29:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        bus_start,
    output logic        bus_write,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INSN = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic [29:0]   insn_ptr;
    logic [CW-1:0] starve_cnt;
    logic          discard;

    logic        starved;
    logic        grant_data;
    logic        grant_fetch;
    logic        drop_resp;
    logic [29:0] issue_ptr;
    logic        head_unused;

    // The halfword bit of the redirect target never addresses a word.
    assign head_unused = head[0];

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        starved     = fetch && (starve_cnt == STARVE_LIM);
        grant_data  = (state == IDLE) && data_start && !starved;
        grant_fetch = (state == IDLE) && fetch && !grant_data;
        // A redirect in the issue cycle must steer the fetch, not the stale pointer.
        issue_ptr   = flush ? head[30:1] : insn_ptr;
        // A redirect arriving with the response also makes that word stale.
        drop_resp   = discard || flush;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order in this block.
    // NOTE: the wide data registers are reset too, so the bus never shows X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            insn_ptr   <= '0;
            starve_cnt <= '0;
            discard    <= 1'b0;
            fetched    <= 1'b0;
            fetch_data <= '0;
            data_ready <= 1'b0;
            data_rdata <= '0;
            bus_start  <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            bus_start  <= 1'b0;
            fetched    <= 1'b0;
            data_ready <= 1'b0;

            if (flush) begin
                insn_ptr <= head[30:1];
            end

            unique case (state)
                IDLE: begin
                    if (grant_data) begin
                        bus_start <= 1'b1;
                        bus_write <= data_write;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        state     <= DATA;
                        if (fetch && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (grant_fetch) begin
                        bus_start  <= 1'b1;
                        bus_write  <= 1'b0;
                        bus_addr   <= issue_ptr;
                        bus_wdata  <= '0;
                        starve_cnt <= '0;
                        discard    <= 1'b0;
                        state      <= INSN;
                    end
                end

                INSN: begin
                    if (bus_ready) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                        if (!drop_resp) begin
                            fetched    <= 1'b1;
                            fetch_data <= bus_rdata;
                            insn_ptr   <= insn_ptr + 30'd1;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end

                DATA: begin
                    if (bus_ready) begin
                        state      <= IDLE;
                        data_ready <= 1'b1;
                        data_rdata <= bus_rdata;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
